// File: rtl/udp_img_pkg.sv
// Shared definitions for the UDP image-line unpacker: FSM encoding and the
// header word layout (sync / flags / line index).
package udp_img_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

  localparam int HDR_SYNC_MSB = 31;
  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_FS_BIT   = 16;
  localparam int HDR_LINE_MSB = 15;
  localparam int HDR_LINE_LSB = 0;

  function automatic logic [7:0] hdr_sync(input logic [31:0] w);
    return w[HDR_SYNC_MSB:HDR_SYNC_LSB];
  endfunction

  function automatic logic hdr_fs(input logic [31:0] w);
    return w[HDR_FS_BIT];
  endfunction

  function automatic logic [15:0] hdr_line(input logic [31:0] w);
    return w[HDR_LINE_MSB:HDR_LINE_LSB];
  endfunction

endpackage

// File: rtl/udp_img_unpack.sv
// Unpacks one RGB565 image line per UDP packet: header check, two-pixel
// serializer per 32-bit word, line completion / error reporting.
module udp_img_unpack
  import udp_img_pkg::*;
#(
  parameter int unsigned IMG_W = 320,
  parameter int unsigned IMG_H = 240,
  parameter logic [7:0]  SYNC  = 8'hF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rec_data_en,
  input  logic [31:0] rec_data,
  input  logic        rec_end,
  input  logic [15:0] rec_data_num,
  output logic        pix_en,
  output logic [15:0] pix_data,
  output logic [15:0] line_num,
  output logic        frame_start,
  output logic        line_end,
  output logic        pkt_err
);

  localparam int             CW         = $clog2(IMG_W + 1);
  localparam int             CWX        = CW + 1;
  localparam logic [CW-1:0]  CNT_MAX    = CW'(IMG_W);
  localparam logic [CWX-1:0] CNT_MAX_X  = CWX'(IMG_W);
  localparam logic [15:0]    LINE_BYTES = 16'(4 + 2 * IMG_W);
  localparam logic [15:0]    IMG_H_W    = 16'(IMG_H);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_pix_cnt;
  logic [15:0]   r_lo_data;
  logic          r_lo_pend;
  logic [1:0]    r_le_sr;

  logic          w_hdr_ok;
  logic          w_pay_word;
  logic          w_emit_hi;
  logic          w_emit_lo;
  logic          w_odd_tail;
  logic          w_hi_go;
  logic          w_lo_go;
  logic [CWX-1:0] w_cnt_p1;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_line_ok;
  logic          w_accept;
  logic          w_err_set;
  logic          w_le_set;
  logic          w_fs_set;

  assign w_hdr_ok   = (hdr_sync(rec_data) == SYNC) && (hdr_line(rec_data) < IMG_H_W);
  assign w_pay_word = (r_state == ST_PAYLOAD) && rec_data_en;
  assign w_cnt_p1   = {1'b0, r_pix_cnt} + {{CW{1'b0}}, 1'b1};
  assign w_emit_hi  = r_pix_cnt < CNT_MAX;
  assign w_emit_lo  = w_cnt_p1 < CNT_MAX_X;
  // A payload ending on a half word leaves a stale lower half in the last word.
  assign w_odd_tail = rec_end && (rec_data_num[1:0] == 2'b10);
  assign w_hi_go    = w_pay_word && w_emit_hi;
  assign w_lo_go    = w_pay_word && w_emit_lo && !w_odd_tail;
  assign w_cnt_nxt  = r_pix_cnt + CW'(w_hi_go) + CW'(w_lo_go);
  assign w_line_ok  = (rec_data_num == LINE_BYTES) && (w_cnt_nxt == CNT_MAX);
  assign w_fs_set   = w_accept && hdr_fs(rec_data) && (hdr_line(rec_data) == 16'h0000);

  // Packet FSM next state and single-cycle event decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err_set   = 1'b0;
    w_le_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rec_data_en) begin
          if (rec_end) begin
            w_err_set = 1'b1;
          end else if (w_hdr_ok) begin
            w_state_nxt = ST_PAYLOAD;
            w_accept    = 1'b1;
          end else begin
            w_state_nxt = ST_DROP;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (rec_end) begin
          w_state_nxt = ST_IDLE;
          if (w_line_ok) begin
            w_le_set = 1'b1;
          end else begin
            w_err_set = 1'b1;
          end
        end else begin
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_DROP: begin
        if (rec_end) begin
          w_state_nxt = ST_IDLE;
          w_err_set   = 1'b1;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register, header capture and pixel counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pix_cnt   <= '0;
      line_num    <= 16'h0000;
      frame_start <= 1'b0;
      pkt_err     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      frame_start <= w_fs_set;
      pkt_err     <= w_err_set;
      if (w_accept) begin
        line_num  <= hdr_line(rec_data);
        r_pix_cnt <= '0;
      end else if (w_pay_word) begin
        r_pix_cnt <= w_cnt_nxt;
      end else begin
        r_pix_cnt <= r_pix_cnt;
      end
    end
  end

  // Two-pixel serializer: upper half next cycle, lower half the cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en    <= 1'b0;
      pix_data  <= 16'h0000;
      r_lo_data <= 16'h0000;
      r_lo_pend <= 1'b0;
    end else begin
      r_lo_pend <= w_lo_go;
      if (w_lo_go) begin
        r_lo_data <= rec_data[15:0];
      end
      if (w_hi_go) begin
        pix_en   <= 1'b1;
        pix_data <= rec_data[31:16];
      end else if (r_lo_pend) begin
        pix_en   <= 1'b1;
        pix_data <= r_lo_data;
      end else begin
        pix_en   <= 1'b0;
      end
    end
  end

  // line_end trails the final pixel by one cycle, whichever half was last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_le_sr  <= 2'b00;
      line_end <= 1'b0;
    end else begin
      line_end <= r_le_sr[0];
      if (w_le_set) begin
        r_le_sr <= w_lo_go ? 2'b10 : 2'b01;
      end else begin
        r_le_sr <= {1'b0, r_le_sr[1]};
      end
    end
  end

endmodule

// File: tb/tb_udp_img_unpack.sv
// Randomized bench for udp_img_unpack with a packet-level reference model.
module tb_udp_img_unpack;

  localparam int          IMG_W = 320;
  localparam int          IMG_H = 240;
  localparam logic [7:0]  SYNC  = 8'hF0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rec_data_en = 1'b0;
  logic [31:0] rec_data = 32'h0;
  logic        rec_end = 1'b0;
  logic [15:0] rec_data_num = 16'h0;
  logic        pix_en;
  logic [15:0] pix_data;
  logic [15:0] line_num;
  logic        frame_start;
  logic        line_end;
  logic        pkt_err;

  udp_img_unpack #(.IMG_W(IMG_W), .IMG_H(IMG_H), .SYNC(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .rec_data_en(rec_data_en), .rec_data(rec_data),
    .rec_end(rec_end), .rec_data_num(rec_data_num), .pix_en(pix_en),
    .pix_data(pix_data), .line_num(line_num), .frame_start(frame_start),
    .line_end(line_end), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] tx_q[$];
  logic [31:0] pw[$];
  int          pt[$];
  logic [15:0] obs_pix[$];
  int          obs_pix_t[$], obs_fs[$], obs_le[$], obs_err[$];
  logic [15:0] exp_pix[$];
  int          exp_pix_t[$], exp_fs[$], exp_le[$], exp_err[$];
  logic [15:0] exp_line = 16'h0;

  always @(negedge clk) begin
    if (pix_en) begin
      obs_pix.push_back(pix_data);
      obs_pix_t.push_back(cyc);
    end
    if (frame_start) obs_fs.push_back(cyc);
    if (line_end)    obs_le.push_back(cyc);
    if (pkt_err)     obs_err.push_back(cyc);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_obs();
    obs_pix.delete(); obs_pix_t.delete(); obs_fs.delete(); obs_le.delete(); obs_err.delete();
  endtask

  task automatic send_word(input logic [31:0] w, input logic last, input logic [15:0] n, input int gap);
    @(posedge clk); #1;
    rec_data_en = 1'b1; rec_data = w; rec_end = last;
    rec_data_num = last ? n : 16'h0;
    pw.push_back(w);
    pt.push_back(cyc + 1);
    @(posedge clk); #1;
    rec_data_en = 1'b0; rec_end = 1'b0;
    repeat (gap - 1) @(posedge clk);
  endtask

  // Reference: derive the expected event stream of one packet from its words.
  task automatic model_pkt(input logic [15:0] n);
    int L;
    logic [31:0] h;
    exp_pix.delete(); exp_pix_t.delete(); exp_fs.delete(); exp_le.delete(); exp_err.delete();
    L = pw.size();
    h = pw[0];
    if (L == 1) begin
      exp_err.push_back(pt[0]);
    end else if (h[31:24] != SYNC || int'(h[15:0]) >= IMG_H) begin
      exp_err.push_back(pt[L-1]);
    end else begin
      exp_line = h[15:0];
      if (h[16] && h[15:0] == 16'h0) exp_fs.push_back(pt[0]);
      for (int k = 1; k < L; k++) begin
        if (exp_pix.size() < IMG_W) begin
          exp_pix.push_back(pw[k][31:16]);
          exp_pix_t.push_back(pt[k]);
        end
        if (!(k == L - 1 && (n % 16'd4) == 16'd2) && exp_pix.size() < IMG_W) begin
          exp_pix.push_back(pw[k][15:0]);
          exp_pix_t.push_back(pt[k] + 1);
        end
      end
      if (int'(n) == 4 + 2 * IMG_W && exp_pix.size() == IMG_W)
        exp_le.push_back(exp_pix_t[exp_pix_t.size()-1] + 1);
      else
        exp_err.push_back(pt[L-1]);
    end
  endtask

  task automatic cmp_times(input string nm, input int got[$], input int exp[$]);
    check_val({nm, ".cnt"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check_val($sformatf("%s.t%0d", nm, i), got[i], exp[i]);
  endtask

  task automatic compare(input string nm);
    check_val({nm, ".npix"}, obs_pix.size(), exp_pix.size());
    for (int i = 0; i < obs_pix.size() && i < exp_pix.size(); i++) begin
      check_val($sformatf("%s.pix%0d", nm, i), obs_pix[i], exp_pix[i]);
      check_val($sformatf("%s.pixt%0d", nm, i), obs_pix_t[i], exp_pix_t[i]);
    end
    cmp_times({nm, ".fs"}, obs_fs, exp_fs);
    cmp_times({nm, ".le"}, obs_le, exp_le);
    cmp_times({nm, ".err"}, obs_err, exp_err);
    check_val({nm, ".line"}, line_num, exp_line);
    clear_obs();
  endtask

  task automatic run_pkt(input logic [15:0] n, input string nm);
    pw.delete(); pt.delete();
    for (int i = 0; i < tx_q.size(); i++)
      send_word(tx_q[i], i == tx_q.size() - 1, n, $urandom_range(2, 7));
    repeat (8) @(posedge clk);
    model_pkt(n);
    compare(nm);
  endtask

  task automatic build(input logic [31:0] hdr, input int nw);
    tx_q.delete();
    tx_q.push_back(hdr);
    for (int i = 0; i < nw; i++) tx_q.push_back($urandom());
  endtask

  initial begin
    logic [31:0] hdr;
    logic [15:0] n;
    int kind, nw;

    #12;
    check_val("rst.pix_en", pix_en, 1'b0);
    check_val("rst.pix_data", pix_data, 16'h0);
    check_val("rst.line_num", line_num, 16'h0);
    check_val("rst.frame_start", frame_start, 1'b0);
    check_val("rst.line_end", line_end, 1'b0);
    check_val("rst.pkt_err", pkt_err, 1'b0);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    clear_obs();

    build(32'hF001_0000, 160);   run_pkt(16'd644, "full_line");
    build(32'hA50A_0003, 160);   run_pkt(16'd644, "bad_sync");
    build(32'hF000_0005, 160);   run_pkt(16'd644, "after_bad");
    build(32'hF000_00F0, 160);   run_pkt(16'd644, "line240");
    build(32'hF000_0009, 159);
    tx_q.push_back(32'h1234_DEAD);
    run_pkt(16'd642, "odd_tail");

    // Reset in the middle of a packet, right as an upper pixel is showing.
    build(32'hF000_0007, 160);
    pw.delete(); pt.delete();
    for (int i = 0; i <= 50; i++)
      send_word(tx_q[i], 1'b0, 16'h0, (i == 50) ? 1 : $urandom_range(2, 7));
    check_val("pre_rst.pix_en", pix_en, 1'b1);
    check_val("pre_rst.pix_data", pix_data, tx_q[50][31:16]);
    check_val("pre_rst.line_num", line_num, 16'd7);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst.pix_en", pix_en, 1'b0);
    check_val("mid_rst.pix_data", pix_data, 16'h0);
    check_val("mid_rst.line_num", line_num, 16'h0);
    #2 rst_n = 1'b1;
    exp_line = 16'h0;
    clear_obs();
    for (int i = 0; i < 51; i++) void'(tx_q.pop_front());
    run_pkt(16'd644, "post_rst");
    build(32'hF001_0000, 160);   run_pkt(16'd644, "post_rst_good");

    build(32'hF000_0011, 170);   run_pkt(16'd684, "overlong");
    build(32'hF000_0002, 0);     run_pkt(16'd4, "hdr_end");

    // rec_end without a word while idle must be ignored.
    @(posedge clk); #1 rec_end = 1'b1; rec_data_num = 16'd644;
    @(posedge clk); #1 rec_end = 1'b0;
    repeat (5) @(posedge clk);
    check_val("idle_end.err", obs_err.size(), 0);
    check_val("idle_end.pix", obs_pix.size(), 0);
    clear_obs();

    for (int p = 0; p < 8; p++) begin
      hdr[31:24] = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : SYNC;
      hdr[23:16] = 8'($urandom());
      hdr[15:0]  = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(240, 300))
                                               : 16'($urandom_range(0, 239));
      if ($urandom_range(0, 3) == 0) hdr[15:0] = 16'h0;
      kind = $urandom_range(0, 3);
      nw = 160;
      case (kind)
        0: n = 16'd644;
        1: begin
          nw = $urandom_range(0, 170);
          n  = 16'(4 + 4 * nw - (($urandom_range(0, 1) == 1) ? 2 : 0));
        end
        2: n = 16'($urandom());
        default: n = 16'd642;
      endcase
      build(hdr, nw);
      run_pkt(n, $sformatf("rnd%0d", p));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/udp_img_unpack.md
UDP_IMG_UNPACK -- requirements
Module: udp_img_unpack

Interface
REQ-001 SHALL have parameter IMG_W, default 320: pixels per image line, one line per UDP packet.
REQ-002 SHALL have parameter IMG_H, default 240: lines per frame.
REQ-003 SHALL have parameter SYNC, default 8'hF0: header sync byte.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rec_data_en, input, 1 bit: pulse marking one received 32-bit word.
REQ-007 SHALL have port rec_data, input, 32 bits: received word; first byte is in [31:24].
REQ-008 SHALL have port rec_end, input, 1 bit: end-of-packet pulse; it coincides with the last rec_data_en.
REQ-009 SHALL have port rec_data_num, input, 16 bits: UDP payload byte count; valid while rec_end is high.
REQ-010 SHALL have port pix_en, output, 1 bit: pixel strobe.
REQ-011 SHALL have port pix_data, output, 16 bits: RGB565 pixel.
REQ-012 SHALL have port line_num, output, 16 bits: line index of the current or last accepted packet.
REQ-013 SHALL have port frame_start, output, 1 bit: pulse on acceptance of the first line of a frame.
REQ-014 SHALL have port line_end, output, 1 bit: pulse when a complete, valid line has been emitted.
REQ-015 SHALL have port pkt_err, output, 1 bit: pulse for a rejected or malformed packet.

Function
REQ-016 SHALL treat the first word of each packet as the header: [31:24] sync, [23:16] flags (bit0 = frame start), [15:0] line index.
REQ-017 SHALL implement states IDLE, PAYLOAD and DROP; reset state is IDLE.
REQ-018 IDLE, on rec_data_en: sync == SYNC and line index < IMG_H -> PAYLOAD, line_num <= index, pixel count cleared; otherwise -> DROP.
REQ-019 SHALL pulse frame_start one cycle after header acceptance when flag bit0 = 1 and line index = 0.
REQ-020 In PAYLOAD, a word at cycle T SHALL produce pix_en with rec_data[31:16] at T+1 and pix_en with rec_data[15:0] at T+2.
REQ-021 SHALL emit only the upper pixel of the last word when (rec_data_num - 4) mod 4 = 2; the stale lower half SHALL NOT be emitted.
REQ-022 SHALL NOT emit any pixel beyond the IMG_W-th in a packet, even while payload words keep arriving.
REQ-023 At rec_end in PAYLOAD, if rec_data_num = 4 + 2*IMG_W, SHALL pulse line_end one cycle after the last pixel.
REQ-024 At rec_end in PAYLOAD with any other rec_data_num, SHALL pulse pkt_err at T+1 and SHALL NOT pulse line_end.
REQ-025 From PAYLOAD or DROP, SHALL return to IDLE on the cycle after rec_end.
REQ-026 In DROP, SHALL emit no pixels and pulse pkt_err one cycle after rec_end.
REQ-027 A header word arriving together with rec_end SHALL give pkt_err at T+1 and leave the state in IDLE.
REQ-028 SHALL ignore rec_end in IDLE when rec_data_en is low.
REQ-029 Input words are spaced at least 8 cycles apart (4-bit MII); the block SHALL need no more than 3-cycle spacing and has no backpressure.
REQ-030 The pixel counter SHALL be $clog2(IMG_W+1) bits wide and saturate at IMG_W.
REQ-031 Byte-count arithmetic SHALL be 16-bit unsigned; rec_data_num < 4 SHALL be treated as a length error.

Reset
REQ-032 On rst_n low, all outputs SHALL be 0 (pix_data = 16'h0, line_num = 16'h0), state IDLE, counters 0, any pending pixel discarded.
REQ-033 After reset is released mid-packet, the block SHALL treat the next rec_data_en as a header.

Structure
REQ-034 State encodings and the header field bit positions SHALL live in shared package udp_img_pkg.
REQ-035 SHALL be a single module with no sub-module; the two-pixel serializer is inline.

Verification
REQ-036 Header F0_01_0000 + 160 payload words, rec_data_num = 644 -> frame_start, 320 pix_en in order, line_end, no pkt_err.
REQ-037 Header with sync A5 -> no pix_en; pkt_err one cycle after rec_end; the next valid packet is accepted.
REQ-038 Line index 240 -> DROP, pkt_err, line_num unchanged.
REQ-039 rec_data_num = 642 with the last word 0x1234_DEAD -> last pixel 0x1234 only, pkt_err, no line_end.
REQ-040 rst_n pulsed low after 50 payload words -> outputs 0 at once; remaining words are parsed as header attempts, and the next good packet completes normally.
REQ-041 170 payload words, rec_data_num = 684 -> exactly 320 pixels emitted, then pkt_err.
